// File: rtl/rvvi_frame_receiver_if.sv
// Stream bundle around the RVVI frame receiver: MAC RX input, payload output
// toward the trace consumer, and the ack stream back to MAC TX.
interface rvvi_frame_receiver_if;
    logic [31:0] RxData;
    logic [3:0]  RxStrb;
    logic        RxValid;
    logic        RxLast;
    logic        RxReady;

    logic [31:0] PayloadData;
    logic [3:0]  PayloadStrb;
    logic        PayloadValid;
    logic        PayloadLast;
    logic        PayloadReady;

    logic [31:0] AckData;
    logic [3:0]  AckStrb;
    logic        AckValid;
    logic        AckLast;
    logic        AckReady;

    // The receiver itself.
    modport slave (
        input  RxData, RxStrb, RxValid, RxLast,
        output RxReady,
        output PayloadData, PayloadStrb, PayloadValid, PayloadLast,
        input  PayloadReady,
        output AckData, AckStrb, AckValid, AckLast,
        input  AckReady
    );

    // The surrounding MAC / consumer side.
    modport master (
        output RxData, RxStrb, RxValid, RxLast,
        input  RxReady,
        input  PayloadData, PayloadStrb, PayloadValid, PayloadLast,
        output PayloadReady,
        input  AckData, AckStrb, AckValid, AckLast,
        output AckReady
    );
endinterface

// File: rtl/rvvi_frame_receiver.sv
// RVVI trace Ethernet receiver: validates header and frame count, forwards
// in-sequence payload and answers every accepted or duplicate frame with an ack.
module rvvi_frame_receiver #(
    parameter logic [47:0] LOCAL_MAC = 48'h8F54_0000_1654,
    parameter logic [15:0] ETH_TYPE  = 16'h005C,
    parameter logic [15:0] ACK_TYPE  = 16'h6B61,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rvvi_frame_receiver_if.slave bus,
    output logic                 FrameDone,
    output logic [63:0]          FrameCount,
    output logic [CNT_WIDTH-1:0] GoodFrames,
    output logic [CNT_WIDTH-1:0] DupFrames,
    output logic [CNT_WIDTH-1:0] DropFrames,
    output logic [CNT_WIDTH-1:0] RuntFrames
);
    typedef enum logic [2:0] {HDR, FWD, DUP, DROP, ACK} state_t;

    state_t      state, stateNext;
    logic [2:0]  wordIdx, ackIdx;
    logic        mismatch;
    logic [47:0] srcMac;
    logic [63:0] count, expectedCount, fullCount;
    logic        fwdDone, dupDone, dropDone, runt;

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign bus.AckStrb = 4'hF;

    always_comb begin
        stateNext        = state;
        bus.RxReady      = 1'b0;
        bus.PayloadData  = '0;
        bus.PayloadStrb  = '0;
        bus.PayloadValid = 1'b0;
        bus.PayloadLast  = 1'b0;
        bus.AckValid     = 1'b0;
        bus.AckData      = '0;
        bus.AckLast      = 1'b0;
        fwdDone          = 1'b0;
        dupDone          = 1'b0;
        dropDone         = 1'b0;
        runt             = 1'b0;
        // On w5 the upper count half is still on the bus, not yet registered.
        fullCount        = (state == HDR) ? {bus.RxData, count[31:0]} : count;
        case (state)
            HDR: begin
                bus.RxReady = 1'b1;
                if (bus.RxValid) begin
                    if (wordIdx == 3'd5) begin
                        if (mismatch || fullCount > expectedCount) begin
                            if (bus.RxLast) dropDone = 1'b1;
                            else            stateNext = DROP;
                        end else if (fullCount == expectedCount) begin
                            if (bus.RxLast) begin
                                fwdDone   = 1'b1;
                                stateNext = ACK;
                            end else begin
                                stateNext = FWD;
                            end
                        end else begin
                            if (bus.RxLast) begin
                                dupDone   = 1'b1;
                                stateNext = ACK;
                            end else begin
                                stateNext = DUP;
                            end
                        end
                    end else if (bus.RxLast) begin
                        runt = 1'b1;
                    end
                end
            end
            FWD: begin
                bus.PayloadData  = bus.RxData;
                bus.PayloadStrb  = bus.RxStrb;
                bus.PayloadLast  = bus.RxLast;
                bus.PayloadValid = bus.RxValid;
                bus.RxReady      = bus.PayloadReady;
                if (bus.RxValid && bus.PayloadReady && bus.RxLast) begin
                    fwdDone   = 1'b1;
                    stateNext = ACK;
                end
            end
            DUP: begin
                bus.RxReady = 1'b1;
                if (bus.RxValid && bus.RxLast) begin
                    dupDone   = 1'b1;
                    stateNext = ACK;
                end
            end
            DROP: begin
                bus.RxReady = 1'b1;
                if (bus.RxValid && bus.RxLast) begin
                    dropDone  = 1'b1;
                    stateNext = HDR;
                end
            end
            ACK: begin
                bus.AckValid = 1'b1;
                bus.AckLast  = (ackIdx == 3'd5);
                case (ackIdx)
                    3'd0:    bus.AckData = srcMac[47:16];
                    3'd1:    bus.AckData = {srcMac[15:0], LOCAL_MAC[47:32]};
                    3'd2:    bus.AckData = LOCAL_MAC[31:0];
                    3'd3:    bus.AckData = {ACK_TYPE, 16'h0000};
                    3'd4:    bus.AckData = count[31:0];
                    3'd5:    bus.AckData = count[63:32];
                    default: bus.AckData = '0;
                endcase
                if (bus.AckReady && ackIdx == 3'd5) stateNext = HDR;
            end
            default: stateNext = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HDR;
            wordIdx       <= '0;
            ackIdx        <= '0;
            mismatch      <= 1'b0;
            srcMac        <= '0;
            count         <= '0;
            expectedCount <= '0;
            FrameDone     <= 1'b0;
            FrameCount    <= '0;
            GoodFrames    <= '0;
            DupFrames     <= '0;
            DropFrames    <= '0;
            RuntFrames    <= '0;
        end else begin
            state     <= stateNext;
            FrameDone <= fwdDone;
            if (state == HDR && bus.RxValid) begin
                wordIdx <= (bus.RxLast || wordIdx == 3'd5) ? 3'd0 : wordIdx + 3'd1;
                // Destination is checked piecewise as it arrives so only srcMac needs storage.
                case (wordIdx)
                    3'd0: mismatch <= (bus.RxData != LOCAL_MAC[47:16]);
                    3'd1: begin
                        mismatch       <= mismatch | (bus.RxData[31:16] != LOCAL_MAC[15:0]);
                        srcMac[47:32]  <= bus.RxData[15:0];
                    end
                    3'd2: srcMac[31:0]   <= bus.RxData;
                    3'd3: mismatch       <= mismatch | (bus.RxData[31:16] != ETH_TYPE);
                    3'd4: count[31:0]    <= bus.RxData;
                    3'd5: count[63:32]   <= bus.RxData;
                    default: ;
                endcase
            end
            if (state == ACK && bus.AckReady)
                ackIdx <= (ackIdx == 3'd5) ? 3'd0 : ackIdx + 3'd1;
            if (fwdDone) begin
                FrameCount    <= fullCount;
                expectedCount <= fullCount + 64'd1;
                GoodFrames    <= satInc(GoodFrames);
            end
            if (dupDone)  DupFrames  <= satInc(DupFrames);
            if (dropDone) DropFrames <= satInc(DropFrames);
            if (runt)     RuntFrames <= satInc(RuntFrames);
        end
    end
endmodule
